// File: rtl/db_dram_arb_if.sv
// Bundle of the two requester ports, the shared response bus and the DRAM command/data port.
// "slave" is the arbiter's view; "master" is the view of the requesters and DRAM model around it.
interface db_dram_arb_if #(
    parameter int RAM_ADDR        = 22,
    parameter int RAM_DWIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [RAM_ADDR-1:0]   req0_addr;
    logic [RAM_DWIDTH-1:0] req0_wdata;
    logic                  rsp0_valid;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [RAM_ADDR-1:0]   req1_addr;
    logic [RAM_DWIDTH-1:0] req1_wdata;
    logic                  rsp1_valid;

    logic [RAM_DWIDTH-1:0] rsp_data;

    logic                  dram_wr_en;
    logic                  dram_rd_en;
    logic [RAM_ADDR-1:0]   dram_addr;
    logic [RAM_DWIDTH-1:0] dram_wr_din;
    logic [RAM_DWIDTH-1:0] dram_rd_dout;
    logic                  dram_rd_valid;

    logic [CNT_W-1:0]      outstanding;
    logic                  err_unexp;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  dram_rd_dout, dram_rd_valid,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output dram_wr_en, dram_rd_en, dram_addr, dram_wr_din,
        output outstanding, err_unexp
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output dram_rd_dout, dram_rd_valid,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  dram_wr_en, dram_rd_en, dram_addr, dram_wr_din,
        input  outstanding, err_unexp
    );
endinterface

// File: rtl/db_dram_arb.sv
// Two-port DRAM arbiter: fixed priority to port 0 with a starvation guard for port 1,
// and an in-order tag FIFO that steers returning read data to the port that issued it.
module db_dram_arb #(
    parameter int RAM_ADDR        = 22,
    parameter int RAM_DWIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int STARVE_LIMIT    = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    db_dram_arb_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [7:0]       STARVE_LIM = 8'(STARVE_LIMIT);

    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [7:0]                 starve_q, starve_d;

    logic                  wr_en_q, rd_en_q;
    logic [RAM_ADDR-1:0]   addr_q;
    logic [RAM_DWIDTH-1:0] wdata_q;
    logic                  rsp0_valid_q, rsp1_valid_q;
    logic [RAM_DWIDTH-1:0] rsp_data_q;
    logic                  err_unexp_q;

    logic                  full, force1, elig0, elig1, grant0, grant1;
    logic                  xfer, sel_we, push, pop, pop_id;
    logic [RAM_ADDR-1:0]   sel_addr;
    logic [RAM_DWIDTH-1:0] sel_wdata;

    // Full looks only at the registered count, so a pop this cycle never frees a slot early.
    assign full   = (count_q == FULL_CNT);
    assign force1 = (starve_q >= STARVE_LIM);
    assign elig0  = bus.req0_valid && (bus.req0_we || !full);
    assign elig1  = bus.req1_valid && (bus.req1_we || !full);
    assign grant1 = elig1 && (force1 || !elig0);
    assign grant0 = elig0 && !grant1;

    assign xfer      = grant0 || grant1;
    assign sel_we    = grant1 ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;

    assign push   = xfer && !sel_we;
    assign pop    = bus.dram_rd_valid && (count_q != '0);
    assign pop_id = tag_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (grant1) begin
            starve_d = 8'd0;
        end else if (bus.req1_valid && (starve_q != 8'hFF)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
            starve_q     <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
            err_unexp_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
            wr_en_q  <= xfer && sel_we;
            rd_en_q  <= xfer && !sel_we;
            if (xfer) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (push) begin
                tag_q[wr_ptr_q] <= grant1;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rsp_data_q <= bus.dram_rd_dout;
            end
            rsp0_valid_q <= pop && !pop_id;
            rsp1_valid_q <= pop && pop_id;
            if (bus.dram_rd_valid && (count_q == '0)) begin
                err_unexp_q <= 1'b1;
            end
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.dram_wr_en  = wr_en_q;
    assign bus.dram_rd_en  = rd_en_q;
    assign bus.dram_addr   = addr_q;
    assign bus.dram_wr_din = wdata_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.outstanding = count_q;
    assign bus.err_unexp   = err_unexp_q;
endmodule

// File: tb/tb_db_dram_arb.sv
// Directed bench for db_dram_arb: a scoreboard queue of expected {port, data} responses,
// an optional fixed-latency DRAM model, and manual read-data beats for the corner cases.
module tb_db_dram_arb;
    localparam int RA = 22;
    localparam int DW = 32;
    localparam int MO = 8;
    localparam int SL = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    db_dram_arb_if #(.RAM_ADDR(RA), .RAM_DWIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

    db_dram_arb #(
        .RAM_ADDR(RA), .RAM_DWIDTH(DW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t sb_q[$];
    rsp_t mon_e;

    logic          auto_ret  = 1'b0;
    logic          man_v     = 1'b0;
    logic [DW-1:0] man_d     = '0;
    logic          auto_v    = 1'b0;
    logic [DW-1:0] auto_d    = '0;
    logic          prev_en   = 1'b0;
    logic [RA-1:0] prev_addr = '0;
    logic          exp1;
    logic [3:0]    pseq;

    assign bus.dram_rd_valid = man_v | auto_v;
    assign bus.dram_rd_dout  = man_v ? man_d : auto_d;

    function automatic logic [DW-1:0] dram_val(input logic [RA-1:0] a);
        return {10'h0, a} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic [DW-1:0] data);
        rsp_t e;
        e.port = port;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_req();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    // DRAM model: read data returns one cycle after the read strobe when enabled
    always @(negedge clk_i) begin
        auto_v    = auto_ret & prev_en;
        auto_d    = dram_val(prev_addr);
        prev_en   = bus.dram_rd_en;
        prev_addr = bus.dram_addr;
    end

    always @(negedge clk_i) begin
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", {bus.rsp1_valid, bus.rsp0_valid}, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_port", {bus.rsp1_valid, bus.rsp0_valid}, mon_e.port ? 2 : 1);
                chk("rsp_data", bus.rsp_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_req();
        #2;
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_err", bus.err_unexp, 0);
        chk("rst_strobes", {bus.dram_wr_en, bus.dram_rd_en}, 0);
        chk("rst_addr", bus.dram_addr, 0);
        chk("rst_wdin", bus.dram_wr_din, 0);
        chk("rst_rsp", {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // single port-0 read
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 22'h000010;
        settle();
        chk("t1_ready0", bus.req0_ready, 1);
        chk("t1_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        chk("t1_rd_en", {bus.dram_wr_en, bus.dram_rd_en}, 2'b01);
        chk("t1_addr", bus.dram_addr, 22'h000010);
        chk("t1_out1", bus.outstanding, 1);
        tick();
        chk("t1_strobe_single", bus.dram_rd_en, 0);
        tick();
        man_v = 1'b1; man_d = 32'hDEADBEEF;
        push_exp(1'b0, 32'hDEADBEEF);
        tick();
        man_v = 1'b0;
        chk("t1_out0", bus.outstanding, 0);
        chk("t1_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b01);
        chk("t1_rsp_data", bus.rsp_data, 32'hDEADBEEF);
        tick();
        chk("t1_rsp_pulse", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("t1_rsp_hold", bus.rsp_data, 32'hDEADBEEF);

        // both ports hold reads: grants 0,0,0,0,1 repeating
        auto_ret = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 22'h000100;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 22'h000200;
        for (int i = 0; i < 10; i++) begin
            settle();
            exp1 = ((i % 5) == 4);
            chk("t2_ready1", bus.req1_ready, exp1);
            chk("t2_ready0", bus.req0_ready, !exp1);
            push_exp(exp1, dram_val(exp1 ? 22'h000200 : 22'h000100));
            tick();
        end
        idle_req();
        repeat (6) tick();
        auto_ret = 1'b0;
        chk("t2_drained", bus.outstanding, 0);

        // fill the tag FIFO with no returns
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.req0_addr = 22'h000300 + 22'(i);
            settle();
            chk("t3_fill_ready", bus.req0_ready, 1);
            tick();
        end
        chk("t3_out_full", bus.outstanding, 8);
        bus.req0_addr  = 22'h0003A0;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 22'h0003B0;
        settle();
        chk("t3_full_ready", {bus.req1_ready, bus.req0_ready}, 0);
        tick();
        bus.req1_we = 1'b1; bus.req1_addr = 22'h0003FF; bus.req1_wdata = 32'h12345678;
        settle();
        chk("t3_wr_ready", {bus.req1_ready, bus.req0_ready}, 2'b10);
        tick();
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0;
        chk("t3_wr_strobe", {bus.dram_wr_en, bus.dram_rd_en}, 2'b10);
        chk("t3_wr_addr", bus.dram_addr, 22'h0003FF);
        chk("t3_wr_din", bus.dram_wr_din, 32'h12345678);
        chk("t3_wr_out", bus.outstanding, 8);
        man_v = 1'b1; man_d = 32'h000000A0;
        push_exp(1'b0, 32'h000000A0);
        settle();
        chk("t3_pop_no_free", bus.req0_ready, 0);
        tick();
        man_v = 1'b0;
        chk("t3_out7", bus.outstanding, 7);
        settle();
        chk("t3_ready_after_pop", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        chk("t3_out_refill", bus.outstanding, 8);
        chk("t3_rd_addr", bus.dram_addr, 22'h0003A0);
        for (int k = 0; k < 8; k++) begin
            man_v = 1'b1; man_d = 32'h000000A1 + 32'(k);
            push_exp(1'b0, 32'h000000A1 + 32'(k));
            tick();
        end
        man_v = 1'b0;
        tick();
        chk("t3_drained", bus.outstanding, 0);

        // interleaved p0,p1,p1,p0 with in-order data 1..4
        pseq = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = !pseq[i]; bus.req0_addr = 22'h000400 + 22'(i);
            bus.req1_valid = pseq[i];  bus.req1_addr = 22'h000400 + 22'(i);
            settle();
            chk("t4_ready", {bus.req1_ready, bus.req0_ready}, pseq[i] ? 2'b10 : 2'b01);
            tick();
        end
        idle_req();
        chk("t4_out4", bus.outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            man_v = 1'b1; man_d = 32'(i + 1);
            push_exp(pseq[i], 32'(i + 1));
            tick();
        end
        man_v = 1'b0;
        tick();
        chk("t4_drained", bus.outstanding, 0);

        // read data with nothing outstanding
        man_v = 1'b1; man_d = 32'h00000055;
        tick();
        man_v = 1'b0;
        chk("t5_err_set", bus.err_unexp, 1);
        chk("t5_out0", bus.outstanding, 0);
        chk("t5_no_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        tick();
        tick();
        chk("t5_err_sticky", bus.err_unexp, 1);
        rst_ni = 1'b0;
        #1;
        chk("t5_async_clear", bus.err_unexp, 0);
        #1;
        rst_ni = 1'b1;
        tick();

        // reset with reads in flight, then stale data beats
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req0_addr = 22'h000500 + 22'(i);
            settle();
            chk("t6_ready", bus.req0_ready, 1);
            tick();
        end
        bus.req0_valid = 1'b0;
        chk("t6_out3", bus.outstanding, 3);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("t6_out_rst", bus.outstanding, 0);
        chk("t6_err_rst", bus.err_unexp, 0);
        for (int i = 0; i < 3; i++) begin
            man_v = 1'b1; man_d = 32'h000000BB + 32'(i);
            tick();
            chk("t6_no_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        end
        man_v = 1'b0;
        tick();
        chk("t6_no_rsp_end", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("t6_err", bus.err_unexp, 1);
        chk("t6_out0", bus.outstanding, 0);

        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/db_dram_arb.md
Name: db_dram_arb

Overview:
- Shares the single DRAM port of the key/value store between two requesters.
- Port 0 is the network lookup path (db_cont); port 1 is the maintenance path (aging/expiry scanner, host table writes).
- Issues at most one command per cycle and applies fixed priority to port 0, with a starvation guard for port 1.
- Tracks outstanding reads so that in-order read data returns to the requester that issued it.

Parameters:
- RAM_ADDR, 22, DRAM word address width.
- RAM_DWIDTH, 32, DRAM data width.
- MAX_OUTSTANDING, 8, maximum reads in flight. Power of two, 2..64.
- STARVE_LIMIT, 4, consecutive port-1 denials before port 1 is forced ahead. Range 1..255.

Ports:
- clk  in  1  system clock; the block runs on this one clock.
- rst  in  1  reset; asynchronous and active-low.
- req0_valid  in  1  port 0 command valid.
- req0_ready  out  1  port 0 command accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  RAM_ADDR  port 0 address.
- req0_wdata  in  RAM_DWIDTH  port 0 write data.
- rsp0_valid  out  1  read data valid for port 0.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata  same as port 0, for port 1.
- rsp1_valid  out  1  read data valid for port 1.
- rsp_data  out  RAM_DWIDTH  read data; shared by both response ports.
- dram_wr_en  out  1  DRAM write strobe.
- dram_rd_en  out  1  DRAM read strobe.
- dram_addr  out  RAM_ADDR  DRAM address.
- dram_wr_din  out  RAM_DWIDTH  DRAM write data.
- dram_rd_dout  in  RAM_DWIDTH  DRAM read data.
- dram_rd_valid  in  1  DRAM read data valid. Returns in order, latency variable, at least 1 cycle.
- outstanding  out  clog2(MAX_OUTSTANDING)+1  reads currently in flight.
- err_unexp  out  1  sticky flag: read data arrived with no read outstanding.

Behaviour:
- Reset (rst low, asynchronous) clears the following, all to 0:
  - every output, including rsp_data, dram_addr and dram_wr_din;
  - the tag FIFO pointers and count;
  - the starvation counter and err_unexp.
- Reset mid-operation: in-flight reads are forgotten. Read data arriving after reset release sets err_unexp and is dropped.
- Handshake:
  - A command transfers when reqN_valid and reqN_ready are both 1.
  - reqN_ready may depend on reqN_valid; reqN_valid must not depend on reqN_ready.
  - A requester holds valid, we, addr and wdata stable until accepted.
- Eligibility: a port is eligible when valid is 1 and either it is a write, or it is a read and the tag FIFO is not full.
- Full is evaluated on the registered count only. A FIFO pop in the same cycle does not free a slot for that cycle.
- Arbitration (combinational, one grant per cycle):
  - force1 = (starve_cnt >= STARVE_LIMIT).
  - If force1 is 1 and port 1 is eligible, port 1 is granted.
  - Otherwise, if port 0 is eligible, port 0 is granted.
  - Otherwise, if port 1 is eligible, port 1 is granted.
  - reqN_ready = grantN.
- Starvation counter (8 bit, saturating at 255):
  - Resets to 0 on any port-1 grant.
  - Increments when req1_valid is 1 and port 1 is not granted.
  - Otherwise holds.
  - A port-1 read blocked by a full FIFO counts as a denial.
- Command issue (registered):
  - A transfer in cycle N drives the DRAM command in cycle N+1: dram_wr_en = we, dram_rd_en = !we, dram_addr and dram_wr_din from the granted port.
  - Strobes are single-cycle; with no transfer both strobes are 0.
  - dram_addr and dram_wr_din hold their last value.
- Tag FIFO:
  - Depth MAX_OUTSTANDING, 1-bit entries holding the port id.
  - Push on read transfer.
  - Pop on dram_rd_valid when count > 0.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo depth.
  - outstanding = count (registered).
  - A read is counted from its transfer cycle, one cycle before dram_rd_en is driven.
- Response:
  - dram_rd_valid in cycle M with count > 0 gives, in cycle M+1: rsp_data = dram_rd_dout, and rsp0_valid or rsp1_valid = 1 per the popped id.
  - Only one rsp valid is high at a time. No backpressure: requesters must always accept.
  - rsp_data holds its value between responses.
- dram_rd_valid with count = 0: sets err_unexp, which stays 1 until reset. No rsp valid and no count change.
- Writes are fire-and-forget and produce no response. Ordering between a write and a later read is DRAM-defined; the arbiter preserves issue order.

Test Plan:
- Port 0 read addr 0x000010, DRAM returns 0xDEADBEEF 3 cycles later:
  - dram_rd_en=1 with dram_addr=0x000010 one cycle after accept;
  - rsp0_valid=1 with rsp_data=0xDEADBEEF one cycle after dram_rd_valid; rsp1_valid stays 0;
  - outstanding goes 0→1→0.
- Both ports hold valid reads continuously, STARVE_LIMIT=4:
  - grant pattern is 0,0,0,0,1 repeating;
  - req1_ready=1 exactly every 5th cycle; starve_cnt returns to 0 after each port-1 grant.
- Issue 8 reads with DRAM never returning:
  - outstanding=8 and both readys are 0 for reads;
  - a port-1 write is still accepted and issued with dram_wr_en=1.
  - Then a single dram_rd_valid: outstanding=7 the cycle after, and a read is accepted the following cycle.
- Interleaved reads p0,p1,p1,p0 returning in order with data 1,2,3,4:
  - responses are rsp0(1), rsp1(2), rsp1(3), rsp0(4).
- dram_rd_valid pulse with no reads outstanding:
  - err_unexp=1 and remains 1; no rsp valid; outstanding=0.
  - Assert rst low asynchronously: err_unexp=0 immediately.
- With 3 reads outstanding, pulse rst low for 1 cycle, then return 3 read data beats:
  - outstanding=0 after reset; no rsp valid for the 3 beats; err_unexp=1.
